// File: rtl/hella_load_requestor_if.sv
// Requestor-side port of the hella-cache arbiter (io_mem_*).
// master = load requestor, slave = arbiter/cache side.
interface hella_load_requestor_if;
  logic        req_ready;
  logic        req_valid;
  logic [39:0] req_bits_addr;
  logic        s1_kill;
  logic        s2_nack;
  logic        resp_valid;
  logic [63:0] resp_bits_data;
  logic        s2_xcpt_ae_ld;

  modport master (
    input  req_ready, s2_nack, resp_valid, resp_bits_data, s2_xcpt_ae_ld,
    output req_valid, req_bits_addr, s1_kill
  );

  modport slave (
    output req_ready, s2_nack, resp_valid, resp_bits_data, s2_xcpt_ae_ld,
    input  req_valid, req_bits_addr, s1_kill
  );
endinterface

// File: rtl/hella_load_requestor.sv
// Single-outstanding 64-bit load client for one hella-cache arbiter requestor port.
// Optional HELLA_REQ_STATS_EN adds saturating nack_count / timeout_count outputs.
//
// state | meaning
// IDLE  | ready for a command
// REQ   | io_mem request valid, waiting for fire
// S1    | fire+1, s1_kill follows cmd_abort
// S2    | fire+2, resolve nack / exception / hit
// WAIT  | response pending, timeout timer running
// RESP  | result held until rsp_ready
module hella_load_requestor #(
  parameter int MAX_RETRIES  = 4,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [39:0] cmd_addr,
  input  logic        cmd_abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_xcpt,
  output logic        rsp_err,
  hella_load_requestor_if.master io_mem
`ifdef HELLA_REQ_STATS_EN
  ,
  output logic [15:0] nack_count,
  output logic [7:0]  timeout_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_WAIT = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  localparam logic [7:0]  LP_MAX_RETRIES = 8'(MAX_RETRIES);
  localparam logic [15:0] LP_TMO_LAST    = 16'(RESP_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [39:0] r_addr;
  logic [7:0]  r_retry;
  logic [15:0] r_timer;
  logic [63:0] r_data;
  logic        r_xcpt;
  logic        r_err;

  logic w_fire;
  logic w_misalign;
  logic w_can_retry;
  logic w_tmo;

  assign w_fire      = (r_state == ST_REQ) && io_mem.req_ready;
  assign w_misalign  = (cmd_addr[2:0] != 3'd0);
  assign w_can_retry = (r_retry < LP_MAX_RETRIES);
  // Timeout only when no data arrives in the same cycle: data wins the tie.
  assign w_tmo       = (r_state == ST_WAIT) && (r_timer == LP_TMO_LAST) && !io_mem.resp_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid) w_next_state = w_misalign ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (w_fire)         w_next_state = ST_S1;
        else if (cmd_abort) w_next_state = ST_IDLE;
      end
      ST_S1:   w_next_state = cmd_abort ? ST_IDLE : ST_S2;
      ST_S2: begin
        if (io_mem.s2_nack)            w_next_state = w_can_retry ? ST_REQ : ST_RESP;
        else if (io_mem.s2_xcpt_ae_ld) w_next_state = ST_RESP;
        else if (io_mem.resp_valid)    w_next_state = ST_RESP;
        else                           w_next_state = ST_WAIT;
      end
      ST_WAIT: if (io_mem.resp_valid || w_tmo) w_next_state = ST_RESP;
      ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready            = (r_state == ST_IDLE);
    io_mem.req_valid     = (r_state == ST_REQ);
    io_mem.req_bits_addr = r_addr;
    io_mem.s1_kill       = (r_state == ST_S1) && cmd_abort;
    rsp_valid            = (r_state == ST_RESP);
    rsp_data             = (r_state == ST_RESP) ? r_data : 64'd0;
    rsp_xcpt             = (r_state == ST_RESP) && r_xcpt;
    rsp_err              = (r_state == ST_RESP) && r_err;
  end

  // Result registers are cleared on command accept so err/xcpt results carry zero data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= 40'd0;
      r_retry <= 8'd0;
      r_timer <= 16'd0;
      r_data  <= 64'd0;
      r_xcpt  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_retry <= 8'd0;
            r_data  <= 64'd0;
            r_xcpt  <= 1'b0;
            r_err   <= w_misalign;
          end
        end
        ST_S2: begin
          if (io_mem.s2_nack) begin
            if (w_can_retry) r_retry <= r_retry + 8'd1;
            else             r_err   <= 1'b1;
          end else if (io_mem.s2_xcpt_ae_ld) begin
            r_xcpt <= 1'b1;
          end else if (io_mem.resp_valid) begin
            r_data <= io_mem.resp_bits_data;
          end else begin
            r_timer <= 16'd0;
          end
        end
        ST_WAIT: begin
          r_timer <= r_timer + 16'd1;
          if (io_mem.resp_valid) r_data <= io_mem.resp_bits_data;
          else if (w_tmo)        r_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HELLA_REQ_STATS_EN
  logic [15:0] r_nack_count;
  logic [7:0]  r_timeout_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_nack_count    <= 16'd0;
      r_timeout_count <= 8'd0;
    end else begin
      if ((r_state == ST_S2) && io_mem.s2_nack && (r_nack_count != 16'hFFFF))
        r_nack_count <= r_nack_count + 16'd1;
      if (w_tmo && (r_timeout_count != 8'hFF))
        r_timeout_count <= r_timeout_count + 8'd1;
    end
  end

  assign nack_count    = r_nack_count;
  assign timeout_count = r_timeout_count;
`endif

endmodule

// File: tb/tb_hella_load_requestor.sv
// Scoreboard bench for hella_load_requestor: a scripted cache responder plus
// a monitor that pops expected results as rsp handshakes complete.
module tb_hella_load_requestor;
  localparam int MAX_RETRIES  = 4;
  localparam int RESP_TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_abort;
  logic [39:0] cmd_addr;
  logic        rsp_valid, rsp_ready, rsp_xcpt, rsp_err;
  logic [63:0] rsp_data;
`ifdef HELLA_REQ_STATS_EN
  logic [15:0] nack_count;
  logic [7:0]  timeout_count;
`endif

  hella_load_requestor_if u_mem ();

  hella_load_requestor #(.MAX_RETRIES(MAX_RETRIES), .RESP_TIMEOUT(RESP_TIMEOUT)) u_dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_abort(cmd_abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_xcpt(rsp_xcpt), .rsp_err(rsp_err),
    .io_mem(u_mem)
`ifdef HELLA_REQ_STATS_EN
    , .nack_count(nack_count), .timeout_count(timeout_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] data;
    logic        xcpt;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          fire_total = 0;
  int          reqv_total = 0;
  int          last_fire_cyc = 0;
  int          lat_obs = 0;
  logic        prev_rv = 1'b0;
  logic [39:0] exp_addr = 40'd0;
  int          cfg_id = 0;
  int          cfg_nacks = 0;
  int          cfg_delay = 0;
  logic        cfg_xcpt = 1'b0;
  logic        cfg_resp = 1'b0;
  logic [63:0] cfg_data = 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cache model and response monitor.
  initial begin
    int   seen_id, nacks_left, resp_cyc;
    logic p1, p2, pend, fire_now;
    exp_t e;
    seen_id = 0; nacks_left = 0; resp_cyc = 0;
    p1 = 1'b0; p2 = 1'b0; pend = 1'b0;
    u_mem.s2_nack = 1'b0; u_mem.s2_xcpt_ae_ld = 1'b0;
    u_mem.resp_valid = 1'b0; u_mem.resp_bits_data = 64'd0;
    forever begin
      @(negedge clock);
      fire_now = u_mem.req_valid && u_mem.req_ready;
      if (u_mem.req_valid) reqv_total++;
      if (fire_now) begin
        fire_total++;
        last_fire_cyc = cyc;
        check("fire_addr", 64'(u_mem.req_bits_addr), 64'(exp_addr));
      end
      if (rsp_valid && !prev_rv) lat_obs = cyc - last_fire_cyc;
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_xcpt", 64'(rsp_xcpt), 64'(e.xcpt));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          if (e.lat >= 0) check("rsp_latency", 64'(lat_obs), 64'(e.lat));
        end
      end
      @(posedge clock);
      #1;
      cyc++;
      if (cfg_id != seen_id) begin
        seen_id = cfg_id; nacks_left = cfg_nacks; pend = 1'b0;
      end
      p2 = p1; p1 = fire_now;
      u_mem.s2_nack = 1'b0; u_mem.s2_xcpt_ae_ld = 1'b0;
      u_mem.resp_valid = 1'b0; u_mem.resp_bits_data = 64'd0;
      if (p2) begin
        if (nacks_left > 0) begin
          // junk data alongside a nack must be ignored
          u_mem.s2_nack = 1'b1; u_mem.resp_valid = 1'b1; u_mem.resp_bits_data = ~cfg_data;
          nacks_left--;
        end else begin
          if (cfg_xcpt) u_mem.s2_xcpt_ae_ld = 1'b1;
          if (cfg_resp) begin pend = 1'b1; resp_cyc = cyc + cfg_delay; end
        end
      end
      if (pend && cyc == resp_cyc) begin
        u_mem.resp_valid = 1'b1; u_mem.resp_bits_data = cfg_data; pend = 1'b0;
      end
    end
  end

  task automatic setup(input logic [39:0] addr, input int nacks, input logic xc,
                       input logic rv, input int dly, input logic [63:0] d);
    cfg_nacks = nacks; cfg_xcpt = xc; cfg_resp = rv; cfg_delay = dly; cfg_data = d;
    exp_addr = addr;
    cfg_id++;
  endtask

  task automatic issue(input logic [39:0] addr);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clock); #1; n++; end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_addr = addr;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin @(posedge clock); #1; n++; end
    check("rsp_arrived", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    @(posedge clock); #1;
  endtask

  task automatic run_load(input logic [39:0] addr, input int nacks, input logic xc,
                          input logic rv, input int dly, input logic [63:0] d,
                          input logic [63:0] ed, input logic ex, input logic ee, input int el);
    setup(addr, nacks, xc, rv, dly, d);
    sb_q.push_back('{data: ed, xcpt: ex, err: ee, lat: el});
    issue(addr);
    wait_done(300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, r0;
`ifdef HELLA_REQ_STATS_EN
    int s0;
`endif
    cmd_valid = 1'b0; cmd_addr = 40'd0; cmd_abort = 1'b0; rsp_ready = 1'b1;
    u_mem.req_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_req_valid", 64'(u_mem.req_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_addr", 64'(u_mem.req_bits_addr), 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // hit at fire+2
    f0 = fire_total;
    run_load(40'h80001000, 0, 1'b0, 1'b1, 0, 64'hDEADBEEF, 64'hDEADBEEF, 1'b0, 1'b0, 3);
    check("hit_fires", 64'(fire_total - f0), 64'd1);

    // two nacks then hit
    f0 = fire_total;
`ifdef HELLA_REQ_STATS_EN
    s0 = int'(nack_count);
`endif
    run_load(40'h80002040, 2, 1'b0, 1'b1, 0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0, 1'b0, 3);
    check("nack_fires", 64'(fire_total - f0), 64'd3);
`ifdef HELLA_REQ_STATS_EN
    check("nack_count", 64'(int'(nack_count) - s0), 64'd2);
`endif

    // retry exhaustion
    f0 = fire_total;
    run_load(40'h00000100, 100, 1'b0, 1'b1, 0, 64'h55, 64'd0, 1'b0, 1'b1, -1);
    check("exhaust_fires", 64'(fire_total - f0), 64'(MAX_RETRIES + 1));

    // exception beats a simultaneous response
    run_load(40'h00000200, 0, 1'b1, 1'b1, 0, 64'h77, 64'd0, 1'b1, 1'b0, 3);

    // misaligned: nothing issued
    f0 = fire_total; r0 = reqv_total;
    run_load(40'h80001004, 0, 1'b0, 1'b1, 0, 64'h99, 64'd0, 1'b0, 1'b1, -1);
    check("misalign_fires", 64'(fire_total - f0), 64'd0);
    check("misalign_reqv", 64'(reqv_total - r0), 64'd0);

    // timeout, then data arriving exactly on the timeout cycle
`ifdef HELLA_REQ_STATS_EN
    s0 = int'(timeout_count);
`endif
    run_load(40'h00000300, 0, 1'b0, 1'b0, 0, 64'h0, 64'd0, 1'b0, 1'b1, RESP_TIMEOUT + 3);
`ifdef HELLA_REQ_STATS_EN
    check("timeout_count", 64'(int'(timeout_count) - s0), 64'd1);
    s0 = int'(timeout_count);
`endif
    run_load(40'h00000308, 0, 1'b0, 1'b1, RESP_TIMEOUT, 64'hCAFEF00D, 64'hCAFEF00D, 1'b0, 1'b0, RESP_TIMEOUT + 3);
`ifdef HELLA_REQ_STATS_EN
    check("tie_no_timeout", 64'(int'(timeout_count) - s0), 64'd0);
`endif

    // result held under rsp_ready backpressure
    rsp_ready = 1'b0;
    setup(40'h00000400, 0, 1'b0, 1'b1, 0, 64'hA5A5);
    sb_q.push_back('{data: 64'hA5A5, xcpt: 1'b0, err: 1'b0, lat: 3});
    issue(40'h00000400);
    repeat (8) @(posedge clock);
    #1;
    check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
    check("hold_rsp_data", rsp_data, 64'hA5A5);
    check("hold_pending", 64'(sb_q.size()), 64'd1);
    rsp_ready = 1'b1;
    wait_done(20);

    // abort in S1 with a stray response at fire+2
    f0 = fire_total;
    setup(40'h00000500, 0, 1'b0, 1'b1, 0, 64'hBAD);
    issue(40'h00000500);
    check("req_no_kill", 64'(u_mem.s1_kill), 64'd0);
    @(posedge clock); #1;
    cmd_abort = 1'b1;
    #1;
    check("s1_kill", 64'(u_mem.s1_kill), 64'd1);
    @(posedge clock); #1;
    cmd_abort = 1'b0;
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort_fires", 64'(fire_total - f0), 64'd1);
    repeat (6) @(posedge clock);
    #1;
    check("abort_no_rsp", 64'(rsp_valid), 64'd0);

    // abort while the request is stalled
    u_mem.req_ready = 1'b0;
    f0 = fire_total;
    setup(40'h00000600, 0, 1'b0, 1'b1, 0, 64'h1);
    issue(40'h00000600);
    for (int i = 0; i < 3; i++) begin
      check("req_held", 64'(u_mem.req_valid), 64'd1);
      @(posedge clock); #1;
    end
    cmd_abort = 1'b1;
    @(posedge clock); #1;
    cmd_abort = 1'b0;
    u_mem.req_ready = 1'b1;
    check("req_abort_idle", 64'(cmd_ready), 64'd1);
    check("req_abort_reqv", 64'(u_mem.req_valid), 64'd0);
    check("req_abort_fires", 64'(fire_total - f0), 64'd0);

    // async reset in WAIT
    setup(40'h00000700, 0, 1'b0, 1'b0, 0, 64'h0);
    issue(40'h00000700);
    repeat (20) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_rsp_err", 64'(rsp_err), 64'd0);
    check("arst_req_valid", 64'(u_mem.req_valid), 64'd0);
    check("arst_kill", 64'(u_mem.s1_kill), 64'd0);
`ifdef HELLA_REQ_STATS_EN
    check("arst_nack_count", 64'(nack_count), 64'd0);
`endif
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (RESP_TIMEOUT + 20) @(posedge clock);
    #1;
    check("no_stale_rsp", 64'(rsp_valid), 64'd0);

    // recovery after reset
    run_load(40'h80001000, 0, 1'b0, 1'b1, 0, 64'h1234, 64'h1234, 1'b0, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
